// File: rtl/text_disp_pkg.sv
// Shared state encoding and glyph geometry for the text display path.
package text_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int GLYPH_H  = 8;
    localparam int GLYPH_W  = 8;
    localparam int GLYPH_AW = 13;

endpackage

// File: rtl/ASCIItoGlyphAddress.sv
// Maps a character code and glyph row pair to a glyph ROM word address.
module ASCIItoGlyphAddress
    import text_disp_pkg::*;
(
    input  logic [7:0]          char_i,
    input  logic [1:0]          row_pair_i,
    output logic [GLYPH_AW-1:0] glyph_addr_o
);

    // Each character owns four ROM words; each word packs two glyph rows.
    assign glyph_addr_o = {{(GLYPH_AW-10){1'b0}}, char_i, 2'b00}
                        + {{(GLYPH_AW-2){1'b0}}, row_pair_i};

endmodule

// File: rtl/text_line_fetcher.sv
// Per-scanline text fetcher: text RAM -> glyph ROM -> MSB-first pixel serialiser,
// prefetching one character ahead of the shifter.
module text_line_fetcher
    import text_disp_pkg::*;
#(
    parameter int COLS    = 80,
    parameter int ROWS    = 60,
    parameter int TEXT_AW = 13
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                LineStart,
    input  logic [8:0]          LineNumber,
    input  logic                PixelEn,
    output logic                TextRdEn,
    output logic [TEXT_AW-1:0]  TextAddr,
    input  logic [7:0]          TextData,
    output logic                GlyphRdEn,
    output logic [GLYPH_AW-1:0] GlyphAddr,
    input  logic [15:0]         GlyphData,
    output logic                Pixel,
    output logic                PixelValid,
    output logic                Busy,
    output logic                Underrun,
    output state_e              DbgState
);

    localparam int COL_W = $clog2(COLS + 1);
    localparam int PIX_W = $clog2(COLS * GLYPH_W + 1);
    localparam logic [COL_W-1:0] COL_END   = COL_W'(COLS);
    localparam logic [PIX_W-1:0] PIX_END   = PIX_W'(COLS * GLYPH_W);
    localparam logic [8:0]       LINE_END  = 9'(ROWS * GLYPH_H);
    localparam logic [3:0]       BITS_LOAD = 4'(GLYPH_W - 1);

    state_e               state_q, state_d;
    logic [TEXT_AW-1:0]   row_base_q, row_base_d;
    logic [2:0]           glyph_line_q, glyph_line_d;
    logic [COL_W-1:0]     fetch_col_q, fetch_col_d;
    logic [PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic                 text_pend_q, text_pend_d;
    logic [7:0]           char_q, char_d;
    logic                 char_vld_q, char_vld_d;
    logic                 glyph_pend_q, glyph_pend_d;
    logic [7:0]           next_byte_q, next_byte_d;
    logic                 next_valid_q, next_valid_d;
    logic [7:0]           shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 pixel_q, pixel_d;
    logic                 pixel_valid_q, pixel_valid_d;
    logic                 underrun_q, underrun_d;
    logic [TEXT_AW-1:0]   text_addr_q;
    logic [GLYPH_AW-1:0]  glyph_addr_q;
    logic [GLYPH_AW-1:0]  glyph_addr_c;
    logic [TEXT_AW-1:0]   row_base_calc;
    logic                 run, in_flight, load, line_ok;

    ASCIItoGlyphAddress u_glyph_addr (
        .char_i       (char_q),
        .row_pair_i   (glyph_line_q[2:1]),
        .glyph_addr_o (glyph_addr_c)
    );

    assign row_base_calc = TEXT_AW'(LineNumber >> $clog2(GLYPH_H)) * TEXT_AW'(COLS);
    assign line_ok       = (LineNumber < LINE_END);

    // Read strobes are single-cycle; data returns one cycle later. Addresses hold when idle.
    assign TextAddr  = TextRdEn  ? (row_base_q + TEXT_AW'(fetch_col_q)) : text_addr_q;
    assign GlyphAddr = GlyphRdEn ? glyph_addr_c : glyph_addr_q;

    always_comb begin
        state_d       = state_q;
        row_base_d    = row_base_q;
        glyph_line_d  = glyph_line_q;
        fetch_col_d   = fetch_col_q;
        pix_cnt_d     = pix_cnt_q;
        char_d        = char_q;
        next_byte_d   = next_byte_q;
        next_valid_d  = next_valid_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        underrun_d    = underrun_q;
        pixel_d       = 1'b0;
        pixel_valid_d = 1'b0;

        run       = (state_q == RUN);
        in_flight = text_pend_q | char_vld_q | glyph_pend_q;
        load      = run && PixelEn && (bit_cnt_q == 4'd0) && next_valid_q;

        // A load frees the prefetch slot, so the next fetch may issue in the same cycle.
        TextRdEn  = !LineStart && run && (fetch_col_q < COL_END)
                    && (!next_valid_q || load) && !in_flight;
        GlyphRdEn = !LineStart && char_vld_q;

        text_pend_d  = TextRdEn;
        char_vld_d   = !LineStart && text_pend_q;
        glyph_pend_d = GlyphRdEn;

        if (TextRdEn)    fetch_col_d = fetch_col_q + 1'b1;
        if (text_pend_q) char_d = TextData;
        if (glyph_pend_q) begin
            next_byte_d  = glyph_line_q[0] ? GlyphData[7:0] : GlyphData[15:8];
            next_valid_d = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (PixelEn) begin
                    pixel_valid_d = 1'b1;
                    pix_cnt_d     = pix_cnt_q + 1'b1;
                    if (load) begin
                        // Bit count holds the bits left after this cycle's pixel.
                        pixel_d      = next_byte_q[7];
                        shift_d      = {next_byte_q[6:0], 1'b0};
                        bit_cnt_d    = BITS_LOAD;
                        next_valid_d = 1'b0;
                    end else if (bit_cnt_q != 4'd0) begin
                        pixel_d   = shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                    end
                    if (pix_cnt_d == PIX_END) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        // LineStart overrides everything and discards any in-flight reads.
        if (LineStart) begin
            state_d       = line_ok ? RUN : IDLE;
            row_base_d    = row_base_calc;
            glyph_line_d  = LineNumber[2:0];
            fetch_col_d   = '0;
            pix_cnt_d     = '0;
            text_pend_d   = 1'b0;
            char_vld_d    = 1'b0;
            glyph_pend_d  = 1'b0;
            next_valid_d  = 1'b0;
            bit_cnt_d     = '0;
            underrun_d    = 1'b0;
            pixel_d       = 1'b0;
            pixel_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            row_base_q    <= '0;
            glyph_line_q  <= '0;
            fetch_col_q   <= '0;
            pix_cnt_q     <= '0;
            text_pend_q   <= 1'b0;
            char_q        <= '0;
            char_vld_q    <= 1'b0;
            glyph_pend_q  <= 1'b0;
            next_byte_q   <= '0;
            next_valid_q  <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            pixel_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
            text_addr_q   <= '0;
            glyph_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            row_base_q    <= row_base_d;
            glyph_line_q  <= glyph_line_d;
            fetch_col_q   <= fetch_col_d;
            pix_cnt_q     <= pix_cnt_d;
            text_pend_q   <= text_pend_d;
            char_q        <= char_d;
            char_vld_q    <= char_vld_d;
            glyph_pend_q  <= glyph_pend_d;
            next_byte_q   <= next_byte_d;
            next_valid_q  <= next_valid_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            underrun_q    <= underrun_d;
            text_addr_q   <= TextAddr;
            glyph_addr_q  <= GlyphAddr;
        end
    end

    assign Pixel      = pixel_q;
    assign PixelValid = pixel_valid_q;
    assign Busy       = run;
    assign Underrun   = underrun_q;
    assign DbgState   = state_q;

endmodule

// File: tb/tb_text_line_fetcher.sv
// Bench for text_line_fetcher: random text/glyph memories, a line-level pixel model,
// and directed steps for start-up, underrun, restart, reset and out-of-range lines.
module tb_text_line_fetcher;
    import text_disp_pkg::*;

    localparam int COLS     = 80;
    localparam int ROWS     = 60;
    localparam int TEXT_AW  = 13;
    localparam int LINE_PIX = COLS * 8;

    logic                Clk = 1'b0;
    logic                Reset_n = 1'b1;
    logic                LineStart = 1'b0;
    logic [8:0]          LineNumber = '0;
    logic                PixelEn = 1'b0;
    logic                TextRdEn;
    logic [TEXT_AW-1:0]  TextAddr;
    logic [7:0]          TextData = '0;
    logic                GlyphRdEn;
    logic [12:0]         GlyphAddr;
    logic [15:0]         GlyphData = '0;
    logic                Pixel;
    logic                PixelValid;
    logic                Busy;
    logic                Underrun;
    state_e              DbgState;

    logic [7:0]  text_mem [0:8191];
    logic [15:0] rom      [0:8191];

    logic [12:0] exp_taddr_q[$];
    logic [12:0] exp_gaddr_q[$];
    logic [0:0]  exp_pix_q[$];

    int          n_assert = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    int          tr_count, gr_count, pv_count;
    logic [12:0] first_taddr, last_taddr, first_gaddr;
    logic [7:0]  first_byte;

    text_line_fetcher #(.COLS(COLS), .ROWS(ROWS), .TEXT_AW(TEXT_AW)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .LineStart  (LineStart),
        .LineNumber (LineNumber),
        .PixelEn    (PixelEn),
        .TextRdEn   (TextRdEn),
        .TextAddr   (TextAddr),
        .TextData   (TextData),
        .GlyphRdEn  (GlyphRdEn),
        .GlyphAddr  (GlyphAddr),
        .GlyphData  (GlyphData),
        .Pixel      (Pixel),
        .PixelValid (PixelValid),
        .Busy       (Busy),
        .Underrun   (Underrun),
        .DbgState   (DbgState)
    );

    // Clock and memories with one-cycle read latency.
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (TextRdEn)  TextData  <= text_mem[TextAddr];
        if (GlyphRdEn) GlyphData <= rom[GlyphAddr];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no end of test, required end before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitor on the falling edge.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (TextRdEn) begin
                tr_count++;
                if (tr_count == 1) first_taddr = TextAddr;
                last_taddr = TextAddr;
                if (exp_taddr_q.size() == 0) chk("text_rd_extra", 32'(TextRdEn), 32'd0);
                else chk("text_addr", 32'(TextAddr), 32'(exp_taddr_q.pop_front()));
            end
            if (GlyphRdEn) begin
                gr_count++;
                if (gr_count == 1) first_gaddr = GlyphAddr;
                if (exp_gaddr_q.size() == 0) chk("glyph_rd_extra", 32'(GlyphRdEn), 32'd0);
                else chk("glyph_addr", 32'(GlyphAddr), 32'(exp_gaddr_q.pop_front()));
            end
            if (PixelValid) begin
                if (pv_count < 8) first_byte = {first_byte[6:0], Pixel};
                pv_count++;
                if (exp_pix_q.size() == 0) chk("pixel_extra", 32'(PixelValid), 32'd0);
                else chk("pixel", 32'(Pixel), 32'(exp_pix_q.pop_front()));
            end
        end
    end

    task automatic clear_sb();
        exp_taddr_q.delete();
        exp_gaddr_q.delete();
        exp_pix_q.delete();
        tr_count = 0;
        gr_count = 0;
        pv_count = 0;
        first_byte = '0;
    endtask

    // Reference: a displayable line is COLS glyph bytes, each sent MSB first.
    task automatic plan_line(input int ln);
        int          base;
        logic [7:0]  ch;
        logic [12:0] ga;
        logic [15:0] w;
        logic [7:0]  b;
        clear_sb();
        if (ln < ROWS * 8) begin
            base = (ln / 8) * COLS;
            for (int c = 0; c < COLS; c++) begin
                ch = text_mem[base + c];
                ga = 13'(int'(ch) * 4 + (ln % 8) / 2);
                w  = rom[ga];
                b  = (ln % 2 == 1) ? w[7:0] : w[15:8];
                exp_taddr_q.push_back(13'(base + c));
                exp_gaddr_q.push_back(ga);
                for (int k = 7; k >= 0; k--) exp_pix_q.push_back(b[k]);
            end
        end
    endtask

    task automatic start_line(input int ln);
        plan_line(ln);
        LineStart  = 1'b1;
        LineNumber = 9'(ln);
        tick();
        LineStart  = 1'b0;
    endtask

    task automatic feed(input int n, input int gap_pct, input bit check_busy);
        int sent;
        sent = 0;
        while (sent < n) begin
            if (int'($urandom_range(99)) < gap_pct) PixelEn = 1'b0;
            else begin
                PixelEn = 1'b1;
                sent++;
            end
            if (check_busy && sent == n && PixelEn) begin
                @(negedge Clk);
                chk("busy_last_pixel", 32'(Busy), 32'd1);
            end
            tick();
        end
        PixelEn = 1'b0;
        if (check_busy) begin
            @(negedge Clk);
            chk("busy_after_last", 32'(Busy), 32'd0);
        end
    endtask

    task automatic finish_line();
        repeat (3) tick();
        @(negedge Clk);
        chk("text_reads_left", 32'(exp_taddr_q.size()), 32'd0);
        chk("glyph_reads_left", 32'(exp_gaddr_q.size()), 32'd0);
        chk("pixels_left", 32'(exp_pix_q.size()), 32'd0);
        chk("pixel_valid_count", 32'(pv_count), 32'(LINE_PIX));
        chk("underrun_line", 32'(Underrun), 32'd0);
        chk("state_idle_after_line", 32'(DbgState), 32'(IDLE));
        tick();
    endtask

    task automatic run_line(input int ln, input int gap_pct);
        start_line(ln);
        repeat (4) tick();
        feed(LINE_PIX, gap_pct, 1'b1);
        finish_line();
    endtask

    initial begin
        int ln;
        for (int i = 0; i < 8192; i++) begin
            text_mem[i] = 8'($urandom);
            rom[i]      = 16'($urandom);
        end
        text_mem[0]  = 8'h41;
        rom[13'h104] = 16'h18FF;
        clear_sb();

        // Power-on reset.
        #2 Reset_n = 1'b0;
        #1;
        chk("reset_outputs", {TextRdEn, TextAddr, GlyphRdEn, GlyphAddr, Pixel, PixelValid,
                              Busy, Underrun}, 32'd0);
        chk("reset_state", 32'(DbgState), 32'(IDLE));
        repeat (2) tick();
        Reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (3) tick();
        @(negedge Clk);
        chk("idle_without_linestart", 32'(Busy), 32'd0);
        chk("no_reads_without_linestart", 32'(tr_count), 32'd0);
        tick();

        // First character 'A', odd glyph line selects the low ROM byte.
        run_line(1, 0);
        chk("first_text_addr", 32'(first_taddr), 32'd0);
        chk("first_glyph_addr", 32'(first_gaddr), 32'h104);
        chk("first_glyph_byte", 32'(first_byte), 32'hFF);

        // Row 2: addresses 160..239, gapless.
        run_line(18, 0);
        chk("row2_first_addr", 32'(first_taddr), 32'd160);
        chk("row2_last_addr", 32'(last_taddr), 32'd239);
        chk("row2_read_count", 32'(tr_count), 32'(COLS));

        // Underrun: pixel requested before any glyph is ready.
        mon_en = 1'b0;
        ln = int'($urandom_range(0, 479));
        start_line(ln);
        PixelEn = 1'b1;
        tick();
        PixelEn = 1'b0;
        @(negedge Clk);
        chk("underrun_pixel_valid", 32'(PixelValid), 32'd1);
        chk("underrun_pixel", 32'(Pixel), 32'd0);
        chk("underrun_flag", 32'(Underrun), 32'd1);
        repeat (3) tick();
        @(negedge Clk);
        chk("underrun_sticky", 32'(Underrun), 32'd1);
        tick();
        mon_en = 1'b1;
        ln = int'($urandom_range(0, 479));
        start_line(ln);
        @(negedge Clk);
        chk("underrun_cleared", 32'(Underrun), 32'd0);
        repeat (4) tick();
        feed(LINE_PIX, 0, 1'b1);
        finish_line();

        // Restart mid-line at pixel 300 with line 9.
        ln = int'($urandom_range(0, 479));
        start_line(ln);
        repeat (4) tick();
        feed(300, 0, 1'b0);
        tick();
        run_line(9, 0);
        chk("restart_first_addr", 32'(first_taddr), 32'd80);

        // Random lines with random PixelEn gaps.
        for (int r = 0; r < 3; r++) begin
            run_line(int'($urandom_range(0, 479)), int'($urandom_range(0, 40)));
        end

        // Reset in the middle of a line.
        start_line(int'($urandom_range(0, 479)));
        repeat (4) tick();
        feed(100, 0, 1'b0);
        mon_en  = 1'b0;
        PixelEn = 1'b1;
        Reset_n = 1'b0;
        #1;
        chk("midline_reset_outputs", {TextRdEn, TextAddr, GlyphRdEn, GlyphAddr, Pixel,
                                      PixelValid, Busy, Underrun}, 32'd0);
        chk("midline_reset_state", 32'(DbgState), 32'(IDLE));
        PixelEn = 1'b0;
        repeat (2) tick();
        Reset_n = 1'b1;
        clear_sb();
        mon_en = 1'b1;
        repeat (6) tick();
        @(negedge Clk);
        chk("post_reset_state", 32'(DbgState), 32'(IDLE));
        chk("post_reset_busy", 32'(Busy), 32'd0);
        chk("post_reset_reads", 32'(tr_count), 32'd0);
        tick();

        // Out-of-range line number is ignored.
        start_line(480);
        @(negedge Clk);
        chk("line480_busy", 32'(Busy), 32'd0);
        chk("line480_state", 32'(DbgState), 32'(IDLE));
        tick();
        PixelEn = 1'b1;
        tick();
        PixelEn = 1'b0;
        @(negedge Clk);
        chk("line480_pixel_valid", 32'(PixelValid), 32'd0);
        repeat (6) tick();
        chk("line480_reads", 32'(tr_count), 32'd0);
        chk("line480_busy_late", 32'(Busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
